// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Bus widths, FSM state encoding and a width helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } arb_state_e;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first
// requester at or after ptr_i, searching upward with wrap.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port,
// ownership per cyc, with a no-ack timeout that returns err.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_M-1:0]         m_cyc_i,
  input  logic [NUM_M-1:0]         m_stb_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [WB_SW*NUM_M-1:0]   m_sel_i,
  input  logic [WB_AW*NUM_M-1:0]   m_adr_i,
  input  logic [WB_DW*NUM_M-1:0]   m_dat_i,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_err_o,
  output logic [WB_DW-1:0]         m_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [WB_SW-1:0]         s_sel_o,
  output logic [WB_AW-1:0]         s_adr_o,
  output logic [WB_DW-1:0]         s_dat_o,
  input  logic                     s_ack_i,
  input  logic [WB_DW-1:0]         s_dat_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic                     timeout_o
);

  localparam int CNT_RAW = clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int IW_RAW  = clog2(NUM_M);
  localparam int IW      = (IW_RAW < 1) ? 1 : IW_RAW;
  localparam bit TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NUM_M - 1);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_M-1:0] pick_gnt;
  logic [IW-1:0]    own;
  logic             busy;
  logic             err;

  wb_rr_pick #(
    .N  (NUM_M),
    .PW (IW)
  ) u_pick (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  assign busy      = (state_q == BUSY);
  assign err       = (state_q == ERR);
  assign grant_o   = grant_q;
  assign timeout_o = err;
  assign m_dat_o   = s_dat_i;

  always_comb begin
    own = '0;
    for (int k = 0; k < NUM_M; k++)
      if (grant_q[k]) own = IW'(k);
  end

  // Slave side is driven only while an owner holds the bus
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[own];
      s_stb_o = m_stb_i[own];
      s_we_o  = m_we_i[own];
      s_sel_o = m_sel_i[own*WB_SW +: WB_SW];
      s_adr_o = m_adr_i[own*WB_AW +: WB_AW];
      s_dat_o = m_dat_i[own*WB_DW +: WB_DW];
    end
  end

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (busy) m_ack_o[own] = s_ack_i;
    if (err)  m_err_o[own] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          grant_d = pick_gnt;
        end
      end
      BUSY: begin
        if (!m_cyc_i[own]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (own == LAST) ? '0 : own + IW'(1);
        end else if (TO_EN && s_stb_o && !s_ack_i) begin
          if (cnt_q == CNT_LIM) state_d = ERR;
          else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = BUSY;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter, two masters, TIMEOUT=4.
// Expected values are hand-computed per scenario.
module tb_wb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [7:0]  m_sel;
  logic [63:0] m_adr, m_dat;
  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_dato, s_adr, s_dato, s_dati;
  logic        s_cyc, s_stb, s_we, s_ack, to;
  logic [3:0]  s_sel;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_M   (2),
    .TIMEOUT (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_sel_i   (m_sel),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_dat_o   (m_dato),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dato),
    .s_ack_i   (s_ack),
    .s_dat_i   (s_dati),
    .grant_o   (grant),
    .timeout_o (to)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic mreq(input int m, input logic c, input logic s);
    m_cyc[m] = c;
    m_stb[m] = s;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [1:0] e;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    m_sel  = '0;
    m_adr  = '0;
    m_dat  = '0;
    s_ack  = 1'b0;
    s_dati = 32'h1234_5678;

    do_reset;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_sctl", {s_cyc, s_stb, s_we}, 3'b000);
    chk("rst_sbus", {s_sel, s_adr}, 0);
    chk("rst_sdat", s_dato, 0);
    chk("rst_merr", {m_ack, m_err, to}, 5'b0);
    chk("rst_mdat", m_dato, 32'h1234_5678);

    // single master write
    m_adr[31:0] = 32'h3000_0004;
    m_dat[31:0] = 32'hDEAD_BEEF;
    m_we[0]     = 1'b1;
    m_sel[3:0]  = 4'hF;
    mreq(0, 1, 1);
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_scyc", s_cyc, 1'b0);
    nxt;
    chk("t1_grant", grant, 2'b01);
    chk("t1_sadr", s_adr, 32'h3000_0004);
    chk("t1_sdat", s_dato, 32'hDEAD_BEEF);
    chk("t1_sctl", {s_cyc, s_stb, s_we}, 3'b111);
    chk("t1_ssel", s_sel, 4'hF);
    chk("t1_noack", m_ack, 2'b00);
    nxt;
    nxt;
    s_ack  = 1'b1;
    s_dati = 32'hCAFE_F00D;
    #1;
    chk("t1_ack", m_ack, 2'b01);
    chk("t1_mdat", m_dato, 32'hCAFE_F00D);
    nxt;
    s_ack = 1'b0;
    mreq(0, 0, 0);
    #1;
    chk("t1_drop_scyc", s_cyc, 1'b0);
    nxt;
    chk("t1_rel_grant", grant, 2'b00);
    chk("t1_rel_scyc", s_cyc, 1'b0);

    // contention from reset
    do_reset;
    m_adr[63:32] = 32'h3000_0100;
    mreq(0, 1, 1);
    mreq(1, 1, 1);
    nxt;
    chk("t2_first_m0", grant, 2'b01);
    s_ack = 1'b1;
    #1;
    chk("t2_ack_m0", m_ack, 2'b01);
    nxt;
    s_ack = 1'b0;
    mreq(0, 0, 0);
    nxt;
    chk("t2_gap", grant, 2'b00);
    chk("t2_gap_scyc", s_cyc, 1'b0);
    nxt;
    chk("t2_second_m1", grant, 2'b10);
    chk("t2_sadr_m1", s_adr, 32'h3000_0100);
    s_ack = 1'b1;
    #1;
    chk("t2_ack_m1", m_ack, 2'b10);
    nxt;
    s_ack = 1'b0;
    mreq(1, 0, 0);
    nxt;
    chk("t2_gap2", grant, 2'b00);
    mreq(0, 1, 1);
    mreq(1, 1, 1);
    nxt;
    chk("t2_alt_m0", grant, 2'b01);
    mreq(0, 0, 0);
    mreq(1, 0, 0);
    nxt;
    nxt;

    // m1 keeps requesting while m0 runs repeated cycles
    do_reset;
    mreq(0, 1, 1);
    mreq(1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      nxt;
      chk($sformatf("t3_grant%0d", k), grant, e);
      s_ack = 1'b1;
      #1;
      chk($sformatf("t3_ack%0d", k), m_ack, e);
      nxt;
      s_ack = 1'b0;
      m_cyc = m_cyc & ~e;
      m_stb = m_stb & ~e;
      nxt;
      chk($sformatf("t3_gap%0d", k), grant, 2'b00);
      m_cyc = m_cyc | e;
      m_stb = m_stb | e;
    end
    m_cyc = '0;
    m_stb = '0;
    nxt;
    nxt;

    // timeout on m1, slave never acks
    do_reset;
    m_adr[63:32] = 32'h3000_0200;
    mreq(1, 1, 1);
    nxt;
    chk("t4_grant", grant, 2'b10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_stb%0d", i), {s_cyc, s_stb}, 2'b11);
      chk($sformatf("t4_noerr%0d", i), {m_err, to}, 3'b000);
      nxt;
    end
    s_ack = 1'b1;
    #1;
    chk("t4_err", m_err, 2'b10);
    chk("t4_to", to, 1'b1);
    chk("t4_scyc", {s_cyc, s_stb}, 2'b00);
    chk("t4_late_ack", m_ack, 2'b00);
    nxt;
    s_ack = 1'b0;
    #1;
    chk("t4_err_clr", {m_err, to}, 3'b000);
    chk("t4_busy_again", {s_cyc, s_stb}, 2'b11);
    chk("t4_grant_kept", grant, 2'b10);
    mreq(1, 0, 0);
    nxt;
    chk("t4_idle", grant, 2'b00);

    // ack in the last allowed stb cycle
    mreq(0, 1, 1);
    nxt;
    chk("t5_grant", grant, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_noerr%0d", i), {m_err, to}, 3'b000);
      nxt;
    end
    s_ack = 1'b1;
    #1;
    chk("t5_ack", m_ack, 2'b01);
    chk("t5_noerr_ack", {m_err, to}, 3'b000);
    nxt;
    s_ack = 1'b0;
    mreq(0, 1, 0);
    #1;
    chk("t5_noerr_after", {m_err, to}, 3'b000);
    chk("t5_still_own", grant, 2'b01);
    chk("t5_scyc", {s_cyc, s_stb}, 2'b10);
    mreq(0, 0, 0);
    nxt;
    chk("t5_idle", grant, 2'b00);

    // async reset while m1 owns the bus (pointer is 1 here)
    mreq(1, 1, 1);
    nxt;
    chk("t6_grant_m1", grant, 2'b10);
    s_ack = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_scyc", {s_cyc, s_stb}, 2'b00);
    chk("t6_rst_outs", {m_ack, m_err, to}, 5'b0);
    s_ack = 1'b0;
    mreq(0, 1, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rel_idle", grant, 2'b00);
    nxt;
    chk("t6_after_m0", grant, 2'b01);
    m_cyc = '0;
    m_stb = '0;
    nxt;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
